// File: rtl/json_decode_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : json_decode_arbiter
//  Function : Round-robin sharing of one JSON decoder core between N_REQ
//             byte-stream requesters, with early-error drain, result timeout
//             and per-requester result return.
//  Revision : 1.0 - initial release
// ============================================================================
module json_decode_arbiter #(
    parameter int N_REQ   = 4,
    parameter int KIND_W  = 4,
    parameter int POS_W   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [8*N_REQ-1:0]       req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output logic [N_REQ-1:0]         rsp_valid,
    input  logic [N_REQ-1:0]         rsp_ready,
    output logic                     rsp_err,
    output logic [KIND_W-1:0]        rsp_kind,
    output logic [POS_W-1:0]         rsp_pos,
    output logic                     core_start,
    output logic                     core_valid,
    output logic [7:0]               core_data,
    output logic                     core_last,
    input  logic                     core_ready,
    input  logic                     core_res_valid,
    input  logic                     core_res_err,
    input  logic [KIND_W-1:0]        core_res_kind,
    input  logic [POS_W-1:0]         core_res_pos,
    output logic                     core_abort,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id
);

    localparam int                c_GW           = $clog2(N_REQ);
    localparam int                c_TO_W         = $clog2(TIMEOUT + 1);
    localparam logic [KIND_W-1:0] c_KIND_TIMEOUT = '1;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_STREAM   = 3'd1,
        S_DRAIN    = 3'd2,
        S_WAIT_RES = 3'd3,
        S_RESP     = 3'd4
    } state_t;

    state_t              r_state, w_next_state;
    logic [c_GW-1:0]     r_rr_ptr, r_grant, w_pick;
    logic [c_GW:0]       w_sum;
    logic [N_REQ-1:0]    w_rot;
    logic                w_any_req;
    logic [POS_W-1:0]    r_byte_cnt;
    logic [c_TO_W-1:0]   r_to_cnt;
    logic                r_rsp_err;
    logic [KIND_W-1:0]   r_rsp_kind;
    logic [POS_W-1:0]    r_rsp_pos;
    logic                r_core_start, r_core_abort;
    logic                w_g_valid, w_g_last;
    logic [7:0]          w_g_data;
    logic [7:0]          w_bytes [N_REQ];
    logic                w_accept, w_last_accept, w_capture, w_to_fire;

    // Unpack the flat byte bus so the granted lane can be selected by index
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign w_bytes[gi] = req_data[8*gi +: 8];
    end

    assign w_g_valid = req_valid[r_grant];
    assign w_g_last  = req_last[r_grant];
    assign w_g_data  = w_bytes[r_grant];

    // Round-robin pick: rotate requests so rr_ptr sits at bit 0, take the lowest set bit
    always_comb begin
        w_rot     = N_REQ'({req_valid, req_valid} >> r_rr_ptr);
        w_any_req = |req_valid;
        w_sum     = {1'b0, r_rr_ptr};
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = {1'b0, r_rr_ptr} + (c_GW+1)'(k);
            end
        end
        if (w_sum >= (c_GW+1)'(N_REQ)) begin
            w_sum = w_sum - (c_GW+1)'(N_REQ);
        end
        w_pick = w_sum[c_GW-1:0];
    end

    // Next-state decode plus the combinational stream path to the core
    always_comb begin
        w_next_state  = r_state;
        req_ready     = '0;
        core_valid    = 1'b0;
        core_data     = 8'd0;
        core_last     = 1'b0;
        w_accept      = 1'b0;
        w_last_accept = 1'b0;
        w_capture     = 1'b0;
        w_to_fire     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) w_next_state = S_STREAM;
            end
            S_STREAM: begin
                req_ready[r_grant] = core_ready;
                core_valid         = w_g_valid;
                core_data          = w_g_data;
                core_last          = w_g_last;
                w_accept           = w_g_valid & core_ready;
                w_last_accept      = w_accept & w_g_last;
                if (core_res_valid) begin
                    // A result before the last byte means the rest of the document must be drained
                    w_capture    = 1'b1;
                    w_next_state = w_last_accept ? S_RESP : S_DRAIN;
                end else if (w_last_accept) begin
                    w_next_state = S_WAIT_RES;
                end
            end
            S_DRAIN: begin
                req_ready[r_grant] = 1'b1;
                if (w_g_valid && w_g_last) w_next_state = S_RESP;
            end
            S_WAIT_RES: begin
                // A result in the final timeout cycle takes priority over the timeout
                if (core_res_valid) begin
                    w_capture    = 1'b1;
                    w_next_state = S_RESP;
                end else if (r_to_cnt == c_TO_W'(TIMEOUT - 1)) begin
                    w_to_fire    = 1'b1;
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready[r_grant]) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    // Grant, counters, captured result and registered control pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr     <= '0;
            r_grant      <= '0;
            r_byte_cnt   <= '0;
            r_to_cnt     <= '0;
            r_rsp_err    <= 1'b0;
            r_rsp_kind   <= '0;
            r_rsp_pos    <= '0;
            r_core_start <= 1'b0;
            r_core_abort <= 1'b0;
        end else begin
            r_core_start <= (r_state == S_IDLE) && w_any_req;
            r_core_abort <= w_to_fire;
            if (r_state == S_IDLE && w_any_req) begin
                r_grant    <= w_pick;
                r_byte_cnt <= '0;
            end else if (w_accept && r_byte_cnt != '1) begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
            end
            if (r_state == S_STREAM)        r_to_cnt <= '0;
            else if (r_state == S_WAIT_RES) r_to_cnt <= r_to_cnt + 1'b1;
            if (w_capture) begin
                r_rsp_err  <= core_res_err;
                r_rsp_kind <= core_res_err ? core_res_kind : '0;
                r_rsp_pos  <= core_res_pos;
            end else if (w_to_fire) begin
                r_rsp_err  <= 1'b1;
                r_rsp_kind <= c_KIND_TIMEOUT;
                r_rsp_pos  <= r_byte_cnt;
            end
            if (r_state == S_RESP && rsp_ready[r_grant]) begin
                r_rr_ptr <= (r_grant == c_GW'(N_REQ - 1)) ? '0 : r_grant + 1'b1;
            end
        end
    end

    assign rsp_valid  = (r_state == S_RESP) ? (N_REQ'(1) << r_grant) : '0;
    assign rsp_err    = r_rsp_err;
    assign rsp_kind   = r_rsp_kind;
    assign rsp_pos    = r_rsp_pos;
    assign core_start = r_core_start;
    assign core_abort = r_core_abort;
    assign busy       = (r_state != S_IDLE);
    assign grant_id   = r_grant;

endmodule
`default_nettype wire
